// File: rtl/usb_rx_nrzi_unstuff_if.sv
// ----------------------------------------------------------------------------
// usb_rx_nrzi_unstuff_if
//   Bundles the line-side inputs and the decoded outputs of the USB RX
//   NRZI decoder / bit unstuffer.
//   master : drives the synchronised lines, bit strobe and flush, and
//            observes the decoded outputs (edge detector / RX control side).
//   slave  : the decoder itself.
//   Signals:
//     d_plus_sync, d_minus_sync  synchronised D+ / D-
//     shift_enable               one strobe per USB bit-time
//     flush                      start-of-packet clear
//     d_orig, bit_valid          last decoded bit and its data qualifier
//     data_out, data_valid       assembled word (first bit in [0]) and strobe
//     stuff_err                  1 seen where a stuffed 0 was required
//     se0_active                 last sample was SE0
//     eop_detected               qualified end of packet
// ----------------------------------------------------------------------------
interface usb_rx_nrzi_unstuff_if #(
    parameter int DATA_W = 8
);
    logic              d_plus_sync;
    logic              d_minus_sync;
    logic              shift_enable;
    logic              flush;
    logic              d_orig;
    logic              bit_valid;
    logic [DATA_W-1:0] data_out;
    logic              data_valid;
    logic              stuff_err;
    logic              se0_active;
    logic              eop_detected;

    modport master (
        output d_plus_sync, d_minus_sync, shift_enable, flush,
        input  d_orig, bit_valid, data_out, data_valid, stuff_err,
               se0_active, eop_detected
    );

    modport slave (
        input  d_plus_sync, d_minus_sync, shift_enable, flush,
        output d_orig, bit_valid, data_out, data_valid, stuff_err,
               se0_active, eop_detected
    );
endinterface

// File: rtl/usb_rx_nrzi_unstuff.sv
// ----------------------------------------------------------------------------
// usb_rx_nrzi_unstuff
//   USB RX line decoder. On every shift_enable strobe the synchronised D+/D-
//   pair is sampled: SE0 samples are counted towards an EOP, other samples
//   are NRZI-decoded (no transition = 1), stuffed zeros are removed after
//   STUFF_LEN consecutive ones, and data bits are deserialised LSB-first
//   into DATA_W-bit words. A J following at least EOP_SE0_BITS SE0 samples
//   is reported as EOP and discards any partial word.
//   Ports:
//     clk   system clock
//     rst   synchronous reset, active high
//     bus   usb_rx_nrzi_unstuff_if.slave (line inputs, decoded outputs)
//   All outputs are registered; pulse outputs last exactly one clock.
// ----------------------------------------------------------------------------
module usb_rx_nrzi_unstuff #(
    parameter int DATA_W       = 8,
    parameter int STUFF_LEN    = 6,
    parameter int EOP_SE0_BITS = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    usb_rx_nrzi_unstuff_if.slave  bus
);
    localparam int ONES_W = $clog2(STUFF_LEN + 1);
    localparam int BIT_W  = $clog2(DATA_W);
    localparam int SE0_W  = $clog2(EOP_SE0_BITS + 1);

    localparam logic [ONES_W-1:0] STUFF_MAX = ONES_W'(STUFF_LEN);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_W - 1);
    localparam logic [SE0_W-1:0]  SE0_MAX   = SE0_W'(EOP_SE0_BITS);

    logic              prev_dp_reg,    prev_dp_next;
    logic [ONES_W-1:0] ones_cnt_reg,   ones_cnt_next;
    logic [BIT_W-1:0]  bit_cnt_reg,    bit_cnt_next;
    logic [SE0_W-1:0]  se0_cnt_reg,    se0_cnt_next;
    logic [DATA_W-1:0] shreg_reg,      shreg_next;
    logic              d_orig_reg,     d_orig_next;
    logic              bit_valid_reg,  bit_valid_next;
    logic [DATA_W-1:0] data_out_reg,   data_out_next;
    logic              data_valid_reg, data_valid_next;
    logic              stuff_err_reg,  stuff_err_next;
    logic              se0_active_reg, se0_active_next;
    logic              eop_reg,        eop_next;

    logic              line_se0;
    logic              line_j;
    logic              raw_bit;
    logic [DATA_W-1:0] word_shifted;

    assign line_se0 = !bus.d_plus_sync && !bus.d_minus_sync;
    assign line_j   =  bus.d_plus_sync && !bus.d_minus_sync;
    // SE1 falls through here as dp=1, which is how it is meant to decode.
    assign raw_bit  = (bus.d_plus_sync == prev_dp_reg);

    // Shift right with the new bit entering the MSB, so after DATA_W bits the
    // first received bit sits in [0].
    genvar gi;
    generate
        for (gi = 0; gi < DATA_W - 1; gi++) begin : g_shift
            assign word_shifted[gi] = shreg_reg[gi+1];
        end
    endgenerate
    assign word_shifted[DATA_W-1] = raw_bit;

    always_comb begin
        prev_dp_next    = prev_dp_reg;
        ones_cnt_next   = ones_cnt_reg;
        bit_cnt_next    = bit_cnt_reg;
        se0_cnt_next    = se0_cnt_reg;
        shreg_next      = shreg_reg;
        d_orig_next     = d_orig_reg;
        data_out_next   = data_out_reg;
        se0_active_next = se0_active_reg;
        bit_valid_next  = 1'b0;
        data_valid_next = 1'b0;
        stuff_err_next  = 1'b0;
        eop_next        = 1'b0;

        if (bus.flush) begin
            // Start of packet: any sample in this cycle is dropped.
            prev_dp_next  = 1'b1;
            ones_cnt_next = '0;
            bit_cnt_next  = '0;
            se0_cnt_next  = '0;
            shreg_next    = '0;
        end else if (bus.shift_enable) begin
            if (line_se0) begin
                se0_active_next = 1'b1;
                if (se0_cnt_reg < SE0_MAX) begin
                    se0_cnt_next = se0_cnt_reg + 1'b1;
                end
            end else if (se0_cnt_reg >= SE0_MAX && line_j) begin
                // Qualified EOP: the J is not a data bit; partial word dropped.
                eop_next        = 1'b1;
                se0_active_next = 1'b0;
                prev_dp_next    = 1'b1;
                ones_cnt_next   = '0;
                bit_cnt_next    = '0;
                se0_cnt_next    = '0;
            end else begin
                se0_active_next = 1'b0;
                se0_cnt_next    = '0;
                prev_dp_next    = bus.d_plus_sync;
                d_orig_next     = raw_bit;
                if (ones_cnt_reg == STUFF_MAX) begin
                    // Stuffed bit slot: must be 0, never enters the word.
                    ones_cnt_next  = '0;
                    stuff_err_next = raw_bit;
                end else begin
                    bit_valid_next = 1'b1;
                    ones_cnt_next  = raw_bit ? ones_cnt_reg + 1'b1 : '0;
                    shreg_next     = word_shifted;
                    if (bit_cnt_reg == BIT_LAST) begin
                        data_out_next   = word_shifted;
                        data_valid_next = 1'b1;
                        bit_cnt_next    = '0;
                    end else begin
                        bit_cnt_next = bit_cnt_reg + 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_dp_reg    <= 1'b1;
            ones_cnt_reg   <= '0;
            bit_cnt_reg    <= '0;
            se0_cnt_reg    <= '0;
            shreg_reg      <= '0;
            d_orig_reg     <= 1'b1;
            bit_valid_reg  <= 1'b0;
            data_out_reg   <= '0;
            data_valid_reg <= 1'b0;
            stuff_err_reg  <= 1'b0;
            se0_active_reg <= 1'b0;
            eop_reg        <= 1'b0;
        end else begin
            prev_dp_reg    <= prev_dp_next;
            ones_cnt_reg   <= ones_cnt_next;
            bit_cnt_reg    <= bit_cnt_next;
            se0_cnt_reg    <= se0_cnt_next;
            shreg_reg      <= shreg_next;
            d_orig_reg     <= d_orig_next;
            bit_valid_reg  <= bit_valid_next;
            data_out_reg   <= data_out_next;
            data_valid_reg <= data_valid_next;
            stuff_err_reg  <= stuff_err_next;
            se0_active_reg <= se0_active_next;
            eop_reg        <= eop_next;
        end
    end

    assign bus.d_orig       = d_orig_reg;
    assign bus.bit_valid    = bit_valid_reg;
    assign bus.data_out     = data_out_reg;
    assign bus.data_valid   = data_valid_reg;
    assign bus.stuff_err    = stuff_err_reg;
    assign bus.se0_active   = se0_active_reg;
    assign bus.eop_detected = eop_reg;
endmodule
